simple_fixed_pipe: RTL

Parametrised, stallable simple-fixed-point execution pipe for the SPU-lite even side. Accepts one 128-bit ALU/logical/shift/compare operation per cycle in halfword or word element mode, with an optional 10-bit signed immediate. Delivers the result with its target register address after a configurable number of stages. Successor to the fixed-latency even-pipe fixed-point stage, adding depth/width parameters, stall, flush, a valid handshake and element-mode selection.

---
 rtl/simple_fixed_pipe.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/simple_fixed_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : simple_fixed_pipe
//  Purpose  : Stallable simple-fixed-point execution pipe (SPU-lite even side).
//             Accepts one REG_W-bit ALU / logical / shift / compare operation
//             per cycle in halfword or word element mode. Rb may be replaced
//             by a sign-extended 10-bit immediate. The result and its target
//             register address are delivered STAGES cycles after acceptance.
//             All computation happens in stage 1. Later stages only delay
//             valid, address and value.
//  Ports    : clock, reset              - clock, synchronous active-high reset
//             in_valid / in_ready       - offer / accept (in_ready = !stall)
//             in_op, in_hw, in_use_imm  - opcode, element mode, immediate select
//             ra, rb, imm10, rt_addr    - operands, immediate, destination
//             stall, flush              - freeze all stages / kill in-flight ops
//             out_valid, out_rt_addr,
//             out_rt_value              - result (out_valid = RF write enable)
//             perf_retired,
//             perf_stall_cyc            - only when FXP_PERF_CNT_EN is defined
//  Options  : `define FXP_PERF_CNT_EN to add the retire / stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module simple_fixed_pipe #(
    parameter int REG_W  = 128,
    parameter int STAGES = 2,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_hw,
    input  logic              in_use_imm,
    input  logic [REG_W-1:0]  ra,
    input  logic [REG_W-1:0]  rb,
    input  logic [9:0]        imm10,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_rt_addr,
    output logic [REG_W-1:0]  out_rt_value
`ifdef FXP_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam int c_NUM_WORDS = REG_W / 32;
    localparam int c_NUM_HALFS = REG_W / 16;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SFX  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NAND = 4'd5;
    localparam logic [3:0] c_OP_NOR  = 4'd6;
    localparam logic [3:0] c_OP_ANDC = 4'd7;
    localparam logic [3:0] c_OP_SHL  = 4'd8;
    localparam logic [3:0] c_OP_ROTL = 4'd9;
    localparam logic [3:0] c_OP_CEQ  = 4'd10;
    localparam logic [3:0] c_OP_CGT  = 4'd11;
    localparam logic [3:0] c_OP_CLGT = 4'd12;
    localparam logic [3:0] c_OP_CLZ  = 4'd13;
    localparam logic [3:0] c_OP_CG   = 4'd14;
    localparam logic [3:0] c_OP_BG   = 4'd15;

    // Count leading zeros of a word; an all-zero word yields 32.
    function automatic logic [31:0] f_clz(input logic [31:0] a);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && a[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return {26'd0, n};
    endfunction

    // One 32-bit element.
    function automatic logic [31:0] f_word(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] sum;
        logic [63:0] rot;
        logic [31:0] res;
        sum = {1'b0, a} + {1'b0, b};
        rot = {a, a} << b[4:0];
        res = '0;
        case (op)
            c_OP_ADD:  res = sum[31:0];
            c_OP_SFX:  res = b - a;
            c_OP_AND:  res = a & b;
            c_OP_OR:   res = a | b;
            c_OP_XOR:  res = a ^ b;
            c_OP_NAND: res = ~(a & b);
            c_OP_NOR:  res = ~(a | b);
            c_OP_ANDC: res = a & ~b;
            // Count is taken mod 64; 32..63 shifts everything out.
            c_OP_SHL:  res = b[5] ? 32'd0 : (a << b[4:0]);
            c_OP_ROTL: res = rot[63:32];
            c_OP_CEQ:  res = {32{a == b}};
            c_OP_CGT:  res = {32{$signed(a) > $signed(b)}};
            c_OP_CLGT: res = {32{a > b}};
            c_OP_CLZ:  res = f_clz(a);
            c_OP_CG:   res = {31'd0, sum[32]};
            c_OP_BG:   res = {31'd0, b >= a};
            default:   res = '0;
        endcase
        return res;
    endfunction

    // One 16-bit element. CLZ is always word mode and never selected here.
    function automatic logic [15:0] f_half(input logic [3:0]  op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] sum;
        logic [31:0] rot;
        logic [15:0] res;
        sum = {1'b0, a} + {1'b0, b};
        rot = {a, a} << b[3:0];
        res = '0;
        case (op)
            c_OP_ADD:  res = sum[15:0];
            c_OP_SFX:  res = b - a;
            c_OP_AND:  res = a & b;
            c_OP_OR:   res = a | b;
            c_OP_XOR:  res = a ^ b;
            c_OP_NAND: res = ~(a & b);
            c_OP_NOR:  res = ~(a | b);
            c_OP_ANDC: res = a & ~b;
            // Count is taken mod 32; 16..31 shifts everything out.
            c_OP_SHL:  res = b[4] ? 16'd0 : (a << b[3:0]);
            c_OP_ROTL: res = rot[31:16];
            c_OP_CEQ:  res = {16{a == b}};
            c_OP_CGT:  res = {16{$signed(a) > $signed(b)}};
            c_OP_CLGT: res = {16{a > b}};
            c_OP_CG:   res = {15'd0, sum[16]};
            c_OP_BG:   res = {15'd0, b >= a};
            default:   res = '0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Stage-1 compute: both element widths are evaluated in parallel and
    // the mode picks one. The immediate is replicated per element.
    // ------------------------------------------------------------------
    logic [31:0]      w_imm_w;
    logic [15:0]      w_imm_h;
    logic [REG_W-1:0] w_res_w;
    logic [REG_W-1:0] w_res_h;
    logic [REG_W-1:0] w_result;
    logic             w_hw_mode;
    logic             w_accept;

    assign w_imm_w = {{22{imm10[9]}}, imm10};
    assign w_imm_h = {{6{imm10[9]}}, imm10};

    for (genvar i = 0; i < c_NUM_WORDS; i++) begin : g_word
        logic [31:0] w_b;
        assign w_b = in_use_imm ? w_imm_w : rb[32*i +: 32];
        assign w_res_w[32*i +: 32] = f_word(in_op, ra[32*i +: 32], w_b);
    end

    for (genvar i = 0; i < c_NUM_HALFS; i++) begin : g_half
        logic [15:0] w_b;
        assign w_b = in_use_imm ? w_imm_h : rb[16*i +: 16];
        assign w_res_h[16*i +: 16] = f_half(in_op, ra[16*i +: 16], w_b);
    end

    assign w_hw_mode = in_hw && (in_op != c_OP_CLZ);
    assign w_result  = w_hw_mode ? w_res_h : w_res_w;
    assign in_ready  = !stall;
    assign w_accept  = in_valid && !stall && !flush;

    // ------------------------------------------------------------------
    // Stage registers. Stage 0 captures the computed result; the rest are
    // a plain delay line. Flush clears valids only, and wins over stall.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_v;
    logic [ADDR_W-1:0] r_addr  [STAGES];
    logic [REG_W-1:0]  r_value [STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_addr[k]  <= '0;
                r_value[k] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
        end else if (!stall) begin
            r_v[0] <= w_accept;
            if (w_accept) begin
                r_addr[0]  <= rt_addr;
                r_value[0] <= w_result;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]     <= r_v[k-1];
                r_addr[k]  <= r_addr[k-1];
                r_value[k] <= r_value[k-1];
            end
        end
    end

    assign out_valid    = r_v[STAGES-1];
    assign out_rt_addr  = r_addr[STAGES-1];
    assign out_rt_value = r_value[STAGES-1];

`ifdef FXP_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall_cyc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_retired   <= '0;
            r_perf_stall_cyc <= '0;
        end else begin
            if (out_valid && !stall) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (stall && (|r_v)) begin
                r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
            end
        end
    end

    assign perf_retired   = r_perf_retired;
    assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule
`default_nettype wire
